// File: rtl/gcd_seq.sv
// Sequential subtractive GCD of two unsigned WIDTH-bit operands, one operation in flight.
// Latency: result valid iters+2 cycles after the accept cycle (one subtraction per CALC cycle).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, then back to IDLE.
module gcd_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] iters,
    output logic             zero_in,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;

    // Working operands; they converge towards the gcd while in CALC.
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] x_nxt;
    logic [WIDTH-1:0] y_nxt;

    logic [WIDTH-1:0] result_nxt;
    logic [WIDTH-1:0] iters_nxt;
    logic             zero_in_nxt;

    // Comparison of the working pair drives both the decision and the subtractor steering.
    logic             either_zero;
    logic             equal;
    logic             x_gt_y;

    // One shared subtractor: always larger minus smaller, so it can never underflow.
    logic [WIDTH-1:0] sub_big;
    logic [WIDTH-1:0] sub_small;
    logic [WIDTH-1:0] diff;

    assign either_zero = (x == '0) || (y == '0);
    assign equal       = (x == y);
    assign x_gt_y      = (x > y);

    assign sub_big     = x_gt_y ? x : y;
    assign sub_small   = x_gt_y ? y : x;
    assign diff        = sub_big - sub_small;

    // Handshake and status outputs decode straight from the state register.
    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign busy        = (state == CALC);

    // Next-state and next-datapath values; every register holds unless a case below updates it.
    always_comb begin
        state_nxt   = state;
        x_nxt       = x;
        y_nxt       = y;
        result_nxt  = result;
        iters_nxt   = iters;
        zero_in_nxt = zero_in;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    x_nxt       = a;
                    y_nxt       = b;
                    iters_nxt   = '0;
                    zero_in_nxt = (a == '0) && (b == '0);
                    state_nxt   = CALC;
                end
            end

            CALC: begin
                if (either_zero) begin
                    // gcd(n,0) = n; both zero yields 0, flagged separately by zero_in.
                    result_nxt = x | y;
                    state_nxt  = DONE;
                end else if (equal) begin
                    result_nxt = x;
                    state_nxt  = DONE;
                end else if (x_gt_y) begin
                    // iters cannot wrap: the worst case (all-ones, 1) stops at 2^WIDTH-2.
                    x_nxt     = diff;
                    iters_nxt = iters + ONE;
                end else begin
                    y_nxt     = diff;
                    iters_nxt = iters + ONE;
                end
            end

            DONE: begin
                // No accept in the consumption cycle: IDLE is entered first.
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            result  <= '0;
            iters   <= '0;
            zero_in <= 1'b0;
        end else begin
            state   <= state_nxt;
            x       <= x_nxt;
            y       <= y_nxt;
            result  <= result_nxt;
            iters   <= iters_nxt;
            zero_in <= zero_in_nxt;
        end
    end

endmodule

// File: tb/tb_gcd_seq.sv
// Scoreboard bench for gcd_seq at WIDTH=8 and WIDTH=16 against a Euclid-based reference.
// Latency: checks result valid exactly iters+2 cycles after the accept cycle.
// Backpressure: directed stall in DONE plus randomized out_ready during random traffic.
module tb_gcd_seq;

    typedef struct {
        logic [15:0] r;
        logic [15:0] it;
        logic        z;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [1:0]  out_ready;
    logic [15:0] a_drv;
    logic [15:0] b_drv;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  busy;
    logic [1:0]  zero_in;
    logic [7:0]  res8;
    logic [7:0]  it8;
    logic [15:0] res16;
    logic [15:0] it16;
    logic [15:0] res_w [2];
    logic [15:0] it_w  [2];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic rnd_en = 1'b0;
    logic [1:0] seen = 2'b00;
    int   first [2];
    exp_t q0 [$];
    exp_t q1 [$];

    gcd_seq #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .a         (a_drv[7:0]),
        .b         (b_drv[7:0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .result    (res8),
        .iters     (it8),
        .zero_in   (zero_in[0]),
        .busy      (busy[0])
    );

    gcd_seq #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .a         (a_drv),
        .b         (b_drv),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .result    (res16),
        .iters     (it16),
        .zero_in   (zero_in[1]),
        .busy      (busy[1])
    );

    assign res_w[0] = {8'd0, res8};
    assign res_w[1] = res16;
    assign it_w[0]  = {8'd0, it8};
    assign it_w[1]  = it16;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: gcd by Euclid's remainder form; the subtractive step count equals the
    // sum of the Euclid quotients minus one (the final equal pair stops without subtracting).
    function automatic void ref_gcd(input int unsigned av, input int unsigned bv,
                                    output int unsigned g, output int unsigned it);
        int unsigned xv, yv, t;
        if (av == 0 || bv == 0) begin
            g  = av | bv;
            it = 0;
        end else begin
            xv = av;
            yv = bv;
            it = 0;
            while (yv != 0) begin
                it += xv / yv;
                t   = xv % yv;
                xv  = yv;
                yv  = t;
            end
            g  = xv;
            it = it - 1;
        end
    endfunction

    task automatic check(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Issue one operation on DUT d; the expected response is queued at the accept cycle.
    task automatic issue(input int d, input logic [15:0] av, input logic [15:0] bv);
        exp_t        e;
        int unsigned g, it;
        int          n;
        ref_gcd(av, bv, g, it);
        e.r  = 16'(g);
        e.it = 16'(it);
        e.z  = (av == 0) && (bv == 0);
        @(posedge clk);
        #1;
        a_drv       = av;
        b_drv       = bv;
        in_valid[d] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready[d] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("accept", in_ready[d], 1);
        if (in_ready[d]) begin
            e.acc = cyc;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid[d] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", out_valid[d], 1);
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", in_ready[d], 1);
    endtask

    task automatic gen(input int d, output logic [15:0] av, output logic [15:0] bv);
        int unsigned g, it;
        logic [15:0] m;
        m = (d == 0) ? 16'h00ff : 16'hffff;
        do begin
            av = 16'($urandom) & m;
            bv = 16'($urandom) & m;
            case ($urandom_range(0, 9))
                0: av = 16'd0;
                1: bv = 16'd0;
                2: bv = av;
                3: begin av = 16'd0; bv = 16'd0; end
                default: ;
            endcase
            ref_gcd(av, bv, g, it);
        end while (it > 400);
    endtask

    // Monitor: pops and compares on every output handshake, independently of stimulus.
    initial forever begin
        exp_t e;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                seen[d] = 1'b0;
            end else if (out_valid[d]) begin
                if (!seen[d]) begin
                    seen[d]  = 1'b1;
                    first[d] = cyc;
                end
                if (out_ready[d]) begin
                    check("unexpected_result_qsize", qsize(d) > 0, 1);
                    if (qsize(d) > 0) begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        check("sb_result", res_w[d], e.r);
                        check("sb_iters", it_w[d], e.it);
                        check("sb_zero_in", zero_in[d], e.z);
                        check("sb_latency", first[d] - e.acc, e.it + 2);
                    end
                    seen[d] = 1'b0;
                end
            end
        end
    end

    // Random out_ready during the randomized phases only.
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_en) out_ready = 2'($urandom_range(0, 3));
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] av, bv;
        int n;
        rst_n     = 1'b1;
        in_valid  = 2'b00;
        out_ready = 2'b11;
        a_drv     = 16'd0;
        b_drv     = 16'd0;
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_in_ready", in_ready[0], 1);
        check("rst_result", res8, 0);
        check("rst_iters", it8, 0);
        check("rst_zero_in", zero_in[0], 0);
        check("rst_in_ready16", in_ready[1], 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Worked example: 12,8 -> 4 after two subtractions.
        issue(0, 16'd12, 16'd8);
        wait_done(0);
        check("d12_8_result", res8, 4);
        check("d12_8_iters", it8, 2);
        check("d12_8_zero", zero_in[0], 0);
        wait_idle(0);

        issue(0, 16'd0, 16'd0);
        wait_done(0);
        check("d0_0_result", res8, 0);
        check("d0_0_iters", it8, 0);
        check("d0_0_zero", zero_in[0], 1);
        wait_idle(0);

        issue(0, 16'd0, 16'd9);
        wait_done(0);
        check("d0_9_result", res8, 9);
        check("d0_9_zero", zero_in[0], 0);
        wait_idle(0);

        issue(0, 16'd255, 16'd1);
        wait_done(0);
        check("d255_1_result", res8, 1);
        check("d255_1_iters", it8, 254);
        wait_idle(0);

        issue(0, 16'd200, 16'd200);
        wait_done(0);
        check("d200_result", res8, 200);
        check("d200_iters", it8, 0);
        wait_idle(0);

        // Stall in DONE: outputs held, in_valid pulses ignored.
        out_ready[0] = 1'b0;
        issue(0, 16'd30, 16'd12);
        wait_done(0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid[0] = (k % 2 == 0);
            a_drv = 16'd7;
            b_drv = 16'd3;
            @(negedge clk);
            check("stall_result", res8, 6);
            check("stall_iters", it8, 3);
            check("stall_zero", zero_in[0], 0);
            check("stall_out_valid", out_valid[0], 1);
            check("stall_in_ready", in_ready[0], 0);
        end
        @(posedge clk);
        #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("release_out_valid", out_valid[0], 1);
        @(negedge clk);
        check("after_out_valid", out_valid[0], 0);
        check("after_in_ready", in_ready[0], 1);
        check("idle_keep_result", res8, 6);
        check("idle_keep_iters", it8, 3);
        @(negedge clk);
        check("idle_no_accept", busy[0], 0);

        // Reset mid-CALC aborts without handshake.
        issue(0, 16'd255, 16'd1);
        repeat (20) @(posedge clk);
        #3;
        check("mid_busy_before", busy[0], 1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid[0], 0);
        check("abort_busy", busy[0], 0);
        check("abort_iters", it8, 0);
        check("abort_in_ready", in_ready[0], 1);
        check("abort_result", res8, 0);
        q0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(0, 16'd21, 16'd14);
        wait_done(0);
        check("d21_14_result", res8, 7);
        check("d21_14_iters", it8, 2);
        wait_idle(0);

        // Randomized back-to-back traffic, WIDTH=8 then WIDTH=16.
        for (int d = 0; d < 2; d++) begin
            rnd_en = 1'b1;
            for (int i = 0; i < 120; i++) begin
                gen(d, av, bv);
                issue(d, av, bv);
            end
            n = 0;
            while (qsize(d) != 0 && n < 5000) begin
                @(posedge clk);
                n++;
            end
            check("drain_qsize", qsize(d), 0);
            rnd_en    = 1'b0;
            @(posedge clk);
            #1;
            out_ready = 2'b11;
        end

        repeat (3) @(negedge clk);
        check("final_q0", q0.size(), 0);
        check("final_q1", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
